mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter. Acts as a responder on the kianv single-cycle CPU data bus (WriteMask/AluResult/WriteData/ReadData), alongside dmem32.
- Top level routes CPU stores in its address window to this block and muxes its rdata into ReadData when sel is high.
- Store bytes are buffered in a small FIFO and serialised as 8N1, LSB first, on uart_tx.

Parameters:
- BASE_ADDR, 32'h1000_0000, base of the 16-byte register window; addr[31:4] must equal BASE_ADDR[31:4].
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64.
- DEFAULT_DIV, 16'd434, reset value of DIV (clock cycles per UART bit).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- wmask  input  4  CPU byte write mask; nonzero means store this cycle.
- addr  input  32  CPU data address (AluResult).
- wdata  input  32  CPU store data.
- rdata  output  32  combinational read data; 0 when sel=0.
- sel  output  1  combinational; 1 when addr[31:4]==BASE_ADDR[31:4].
- uart_tx  output  1  registered serial output; idle high.

Behaviour:
- Register map (offset = addr[3:2]):
  - 0 TXDATA (W): store with wmask[0]=1 pushes wdata[7:0]. Reads return 0.
  - 1 STATUS (R/W1C):
    - bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky).
    - bits[15:8] FIFO count, zero-extended.
    - Store with wmask[0]=1 and wdata[3]=1 clears overflow. No other fields are writable.
  - 2 DIV (R/W): bits[15:0]. wmask[0] writes [7:0], wmask[1] writes [15:8]. Reads return zero-extended value. Takes effect at the next bit boundary.
  - 3: reads 0; writes ignored.
- Register read is combinational (single-cycle CPU). Writes commit on the clk edge where sel=1 and the relevant wmask bit is set.
- Effective bit period = max(DIV,1) cycles.
- Reset (synchronous, active-high):
  - uart_tx=1, FSM=IDLE, FIFO empty (count=0), overflow=0, DIV=DEFAULT_DIV, bit counter=0, baud counter=0.
  - Reset mid-frame aborts the frame immediately: uart_tx=1 the cycle after the reset edge, and queued bytes are discarded.
- FIFO:
  - Circular buffer with read/write pointers and a separate count register. Pointers wrap at FIFO_DEPTH.
  - A push when count==FIFO_DEPTH is accepted only if a pop occurs in the same cycle. Otherwise the byte is dropped, overflow<=1, and count is unchanged.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty at an edge, pop the head into the shift register, go to START, uart_tx<=0, baud counter<=0.
  - START: hold 0 for one bit period, then go to DATA with uart_tx<=shift[0] and bit index=0.
  - DATA: each bit held one period; shift right. After bit index 7 completes, go to STOP with uart_tx<=1.
  - STOP: hold 1 for one bit period, then:
    - FIFO non-empty: pop and go directly to START (uart_tx<=0), so frames are back-to-back with no idle gap.
    - FIFO empty: go to IDLE.
- Latency: a store committing at edge N makes count=1 visible after N. At edge N+1 the FSM pops and uart_tx falls (empty=0 is visible only between N and N+1).
- Frame length is exactly 10×max(DIV,1) cycles.
- busy=1 from the START entry edge until the STOP→IDLE edge.

Test Plan:
- Reset, DIV=4, store 0x55 to TXDATA -> uart_tx low 1 cycle later for 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles. busy=1 for 40 cycles, then empty=1, busy=0.
- DIV=2, 9 back-to-back stores (0x00..0x08) with FIFO_DEPTH=8 -> the first is popped immediately, so all 9 are accepted and overflow=0. A 10th store before any further pop -> dropped, STATUS bit3=1, count=8. Frames are contiguous with no idle gap. W1C store with wdata=0x8 clears overflow.
- Store with wmask=4'b0010 to TXDATA -> no push, count stays 0. Store wmask=4'b0011, wdata=0x0003 to DIV -> reads back 0x00000003.
- DIV=0 -> bit period is 1 cycle; byte 0xA5 produces a 10-cycle frame.
- Assert reset during DATA bit 3 with 3 bytes queued -> uart_tx=1 the next cycle, STATUS reads 0x00000002, DIV=434.
- addr outside window (0x0000_0100) with wmask=4'hF -> sel=0, rdata=0, no state change. Reading offset 0xC in window -> rdata=0.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, responding on the CPU data bus.
// Register window: TXDATA, STATUS (W1C overflow), DIV (bit period in clocks).
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  wmask,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        uart_tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   div_q, div_d;
    logic [15:0]   period_q, period_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic [1:0]  off;
    logic        push_req, push_acc, pop;
    logic        w1c, div_lo_we, div_hi_we;
    logic        full, empty, busy, bit_done;
    logic [15:0] eff_div;
    logic        unused_bits;

    assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
    assign off       = addr[3:2];
    assign push_req  = sel && wmask[0] && (off == 2'd0);
    assign w1c       = sel && wmask[0] && (off == 2'd1) && wdata[3];
    assign div_lo_we = sel && wmask[0] && (off == 2'd2);
    assign div_hi_we = sel && wmask[1] && (off == 2'd2);

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign busy     = (state_q != S_IDLE);
    assign eff_div  = (div_q == 16'd0) ? 16'd1 : div_q;
    assign bit_done = (baud_q == period_q - 16'd1);
    assign uart_tx  = tx_q;

    assign unused_bits = ^{addr[1:0], wdata[31:16], wmask[3:2]};

    // Serialiser: the period is latched at each bit start so DIV changes land on a boundary
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        tx_d      = tx_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        baud_d    = baud_q + 16'd1;
        period_d  = period_q;
        case (state_q)
            S_IDLE: begin
                baud_d = 16'd0;
                tx_d   = 1'b1;
                if (!empty) begin
                    pop      = 1'b1;
                    shift_d  = mem_q[rd_ptr_q];
                    state_d  = S_START;
                    tx_d     = 1'b0;
                    period_d = eff_div;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d   = S_DATA;
                    tx_d      = shift_q[0];
                    bit_idx_d = 3'd0;
                    baud_d    = 16'd0;
                    period_d  = eff_div;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    baud_d   = 16'd0;
                    period_d = eff_div;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    baud_d   = 16'd0;
                    period_d = eff_div;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO bookkeeping and register writes; a full FIFO still accepts when a pop frees a slot
    always_comb begin
        push_acc   = push_req && (!full || pop);
        wr_ptr_d   = wr_ptr_q + PW'(push_acc);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        count_d    = count_q;
        if (push_acc && !pop) count_d = count_q + CW'(1);
        if (!push_acc && pop) count_d = count_q - CW'(1);
        overflow_d = overflow_q;
        if (w1c) overflow_d = 1'b0;
        if (push_req && !push_acc) overflow_d = 1'b1;
        div_d = div_q;
        if (div_lo_we) div_d[7:0]  = wdata[7:0];
        if (div_hi_we) div_d[15:8] = wdata[15:8];
    end

    always_comb begin
        rdata = 32'd0;
        if (sel) begin
            case (off)
                2'd1: begin
                    rdata[0]    = full;
                    rdata[1]    = empty;
                    rdata[2]    = busy;
                    rdata[3]    = overflow_q;
                    rdata[15:8] = 8'(count_q);
                end
                2'd2:    rdata[15:0] = div_q;
                default: rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            div_q      <= DEFAULT_DIV;
            period_q   <= 16'd1;
            baud_q     <= 16'd0;
            bit_idx_q  <= 3'd0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            div_q      <= div_d;
            period_q   <= period_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        if (push_acc) mem_q[wr_ptr_q] <= wdata[7:0];
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: register vectors, directed frame sequences and random traffic
// checked against a per-cycle waveform model of back-to-back 8N1 frames.
module tb_mmio_uart_tx;

    localparam logic [31:0] A_TX = 32'h1000_0000;
    localparam logic [31:0] A_ST = 32'h1000_0004;
    localparam logic [31:0] A_DV = 32'h1000_0008;

    logic        clk;
    logic        reset;
    logic [3:0]  wmask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        sel;
    logic        uart_tx;

    mmio_uart_tx #(
        .BASE_ADDR  (32'h1000_0000),
        .FIFO_DEPTH (8),
        .DEFAULT_DIV(16'd434)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .wmask  (wmask),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .sel    (sel),
        .uart_tx(uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] exp_q[$];
    int         p_eff;
    int         t0;

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdat;
        logic [3:0]  wm;
        logic [31:0] raddr;
        logic        exp_sel;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr  = a;
        wdata = d;
        wmask = m;
        tick();
        wmask = 4'd0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic s);
        addr  = a;
        wmask = 4'd0;
        #1;
        d = rdata;
        s = sel;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Line level of cycle k of a frame carrying byte b with p clocks per bit
    function automatic logic frame_bit(input logic [7:0] b, input int k, input int p);
        int slot;
        slot = k / p;
        if (slot == 0) return 1'b0;
        if (slot >= 9) return 1'b1;
        return b[3'(slot - 1)];
    endfunction

    // Frames for exp_q run contiguously from the edge after store edge t0
    task automatic check_stream();
        int total, k, j, flen;
        int mism[16];
        bit seen[16];
        for (int i = 0; i < 16; i++) begin
            mism[i] = 0;
            seen[i] = 1'b0;
        end
        flen  = 10 * p_eff;
        total = exp_q.size() * flen;
        addr  = A_ST;
        wmask = 4'd0;
        #1;
        k = cyc_cnt - t0 - 1;
        while (k < total) begin
            if (k >= 0) begin
                j = k / flen;
                seen[j] = 1'b1;
                if (uart_tx !== frame_bit(exp_q[j], k % flen, p_eff)) mism[j]++;
                if (rdata[2] !== 1'b1) mism[j]++;
            end
            tick();
            k = cyc_cnt - t0 - 1;
        end
        for (int i = 0; i < exp_q.size(); i++)
            if (seen[i]) chk($sformatf("frame%0d_p%0d", i, p_eff), mism[i], 0);
        chk("idle_tx", {31'd0, uart_tx}, 32'd1);
        chk("idle_status", rdata, 32'h0000_0002);
    endtask

    logic [31:0] rv;
    logic        sv;
    logic [3:0]  rm;
    logic [7:0]  rb;
    int          dv, nb, errs;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        wmask = 4'd0;
        addr  = 32'd0;
        wdata = 32'd0;
        do_reset();
        chk("reset_tx", {31'd0, uart_tx}, 32'd1);

        vecs[0]  = '{32'd0, 32'd0, 4'h0, A_ST, 1'b1, 32'h0000_0002};
        vecs[1]  = '{32'd0, 32'd0, 4'h0, A_DV, 1'b1, 32'h0000_01B2};
        vecs[2]  = '{A_TX, 32'h41, 4'b0010, A_ST, 1'b1, 32'h0000_0002};
        vecs[3]  = '{A_DV, 32'h0003, 4'b0011, A_DV, 1'b1, 32'h0000_0003};
        vecs[4]  = '{A_DV, 32'h0500, 4'b0010, A_DV, 1'b1, 32'h0000_0503};
        vecs[5]  = '{A_DV, 32'h00FF, 4'b0001, 32'h1000_0009, 1'b1, 32'h0000_05FF};
        vecs[6]  = '{A_DV, 32'hFFFF_FFFF, 4'b1100, A_DV, 1'b1, 32'h0000_05FF};
        vecs[7]  = '{32'h0000_0108, 32'h1234, 4'hF, 32'h0000_0100, 1'b0, 32'h0};
        vecs[8]  = '{32'd0, 32'd0, 4'h0, A_DV, 1'b1, 32'h0000_05FF};
        vecs[9]  = '{32'd0, 32'd0, 4'h0, 32'h1000_000C, 1'b1, 32'h0};
        vecs[10] = '{32'd0, 32'd0, 4'h0, A_TX, 1'b1, 32'h0};
        vecs[11] = '{A_ST, 32'hFFFF_FFFF, 4'hF, A_ST, 1'b1, 32'h0000_0002};
        vecs[12] = '{32'h1000_000C, 32'hFFFF_FFFF, 4'hF, A_DV, 1'b1, 32'h0000_05FF};
        vecs[13] = '{32'h0000_0100, 32'h77, 4'hF, A_ST, 1'b1, 32'h0000_0002};
        vecs[14] = '{32'd0, 32'd0, 4'h0, 32'h1000_0014, 1'b0, 32'h0};

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wm != 4'd0) wr(vecs[i].waddr, vecs[i].wdat, vecs[i].wm);
            else tick();
            rd(vecs[i].raddr, rv, sv);
            chk($sformatf("vec%0d_sel", i), {31'd0, sv}, {31'd0, vecs[i].exp_sel});
            chk($sformatf("vec%0d_rdata", i), rv, vecs[i].exp_rd);
        end
        chk("vec_tx_idle", {31'd0, uart_tx}, 32'd1);

        // DIV=4, single byte 0x55
        wr(A_DV, 32'd4, 4'b0011);
        p_eff = 4;
        exp_q.delete();
        exp_q.push_back(8'h55);
        wr(A_TX, 32'h55, 4'b0001);
        t0 = cyc_cnt;
        rd(A_ST, rv, sv);
        chk("single_status_n", rv, 32'h0000_0100);
        chk("single_tx_n", {31'd0, uart_tx}, 32'd1);
        check_stream();

        // DIV=2, fill past the FIFO depth
        wr(A_DV, 32'd2, 4'b0011);
        p_eff = 2;
        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(8'(i));
            wr(A_TX, 32'(i), 4'b0001);
            if (i == 0) t0 = cyc_cnt;
        end
        rd(A_ST, rv, sv);
        chk("ovf_full_status", rv, 32'h0000_0805);
        wr(A_TX, 32'h09, 4'hF);
        rd(A_ST, rv, sv);
        chk("ovf_drop_status", rv, 32'h0000_080D);
        wr(A_ST, 32'h8, 4'b0001);
        rd(A_ST, rv, sv);
        chk("ovf_clear_status", rv, 32'h0000_0805);
        check_stream();

        // DIV=0 behaves as a one-clock bit period
        wr(A_DV, 32'd0, 4'b0011);
        rd(A_DV, rv, sv);
        chk("div0_read", rv, 32'd0);
        p_eff = 1;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        wr(A_TX, 32'hA5, 4'b0001);
        t0 = cyc_cnt;
        check_stream();

        // Reset during data bit 3 of the first of four queued bytes
        wr(A_DV, 32'd4, 4'b0011);
        wr(A_TX, 32'h00, 4'b0001);
        t0 = cyc_cnt;
        wr(A_TX, 32'h11, 4'b0001);
        wr(A_TX, 32'h22, 4'b0001);
        wr(A_TX, 32'h33, 4'b0001);
        while (cyc_cnt < t0 + 19) tick();
        chk("pre_reset_tx", {31'd0, uart_tx}, 32'd0);
        reset = 1'b1;
        tick();
        chk("reset_mid_tx", {31'd0, uart_tx}, 32'd1);
        reset = 1'b0;
        rd(A_ST, rv, sv);
        chk("reset_mid_status", rv, 32'h0000_0002);
        rd(A_DV, rv, sv);
        chk("reset_mid_div", rv, 32'h0000_01B2);
        errs = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (uart_tx !== 1'b1) errs++;
        end
        chk("reset_discard_tx", errs, 0);
        rd(A_ST, rv, sv);
        chk("reset_discard_status", rv, 32'h0000_0002);

        // Random bursts against the frame model
        for (int it = 0; it < 6; it++) begin
            dv = $urandom_range(0, 4);
            nb = $urandom_range(1, 9);
            wr(A_DV, 32'(dv), 4'b0011);
            p_eff = (dv == 0) ? 1 : dv;
            exp_q.delete();
            for (int i = 0; i < nb; i++) begin
                rb = 8'($urandom);
                rm = 4'($urandom_range(0, 15)) | 4'b0001;
                exp_q.push_back(rb);
                wr(A_TX, {$urandom, rb} >> 0 & 32'h0000_00FF | (32'($urandom) & 32'hFFFF_FF00), rm);
                if (i == 0) t0 = cyc_cnt;
            end
            check_stream();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
